// File: rtl/serial_paralelo_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_paralelo_rx_pkg
//  Description : Constants and types shared by the Phy serial blocks
//                (RX serial-to-parallel and TX parallel-to-serial).
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_paralelo_rx_pkg;

  // Width of one deserialized character
  localparam int C_BYTE_W = 8;

  // Idle / alignment character; never delivered as valid data
  localparam logic [C_BYTE_W-1:0] C_COMMA = 8'hBC;

  // Receiver state encodings
  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_ALIGN  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  // Registered output bundle of the receiver
  typedef struct packed {
    logic                active;
    logic                valid;
    logic [C_BYTE_W-1:0] data;
    logic                strobe;
  } rx_out_t;

  // Comma comparator shared by both directions of the Phy
  function automatic logic is_comma(input logic [C_BYTE_W-1:0] b,
                                    input logic [C_BYTE_W-1:0] c);
    return (b == c);
  endfunction

endpackage : serial_paralelo_rx_pkg
`default_nettype wire

// File: rtl/serial_paralelo_rx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_paralelo_rx
//  Description : Receive-side serial-to-parallel converter. Finds byte
//                alignment from the comma character, declares the link
//                active after COMMA_COUNT consecutive aligned commas, then
//                presents every received byte once per 8 bit clocks with a
//                valid flag that is low for commas.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_paralelo_rx
  import serial_paralelo_rx_pkg::*;
#(
  parameter logic [C_BYTE_W-1:0] COMMA       = C_COMMA,
  parameter int                  COMMA_COUNT = 4
) (
  input  logic                clk_32f,
  input  logic                reset_L,
  input  logic                data_in,
  output logic                active,
  output logic                valid_out,
  output logic [C_BYTE_W-1:0] data_out,
  output logic                byte_strobe
);

  // Commas required for lock, held in the same width as the comma counter
  localparam logic [3:0] C_COMMA_TARGET = 4'(COMMA_COUNT);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]          r_state;
  logic [C_BYTE_W-1:0] r_sr;
  logic [2:0]          r_bit_cnt;
  logic [3:0]          r_comma_cnt;
  rx_out_t             r_out;

  // --------------------------------------------------------------------------
  // Combinational next values
  // --------------------------------------------------------------------------
  logic [C_BYTE_W-1:0] w_nb;
  logic                w_nb_is_comma;
  logic                w_boundary;
  logic [1:0]          w_state_nxt;
  logic [2:0]          w_bit_cnt_nxt;
  logic [3:0]          w_comma_cnt_nxt;
  logic [3:0]          w_comma_cnt_inc;
  rx_out_t             w_out_nxt;

  // Candidate byte including the bit being sampled on this edge
  assign w_nb            = {r_sr[C_BYTE_W-2:0], data_in};
  assign w_nb_is_comma   = is_comma(w_nb, COMMA);
  // The 8th bit of an aligned byte arrives when the counter sits at 7
  assign w_boundary      = (r_bit_cnt == 3'd7);
  assign w_comma_cnt_inc = r_comma_cnt + 4'd1;

  // State, shift register, counters and output registers
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= ST_SEARCH;
      r_sr        <= '0;
      r_bit_cnt   <= 3'd0;
      r_comma_cnt <= 4'd0;
      r_out       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sr        <= w_nb;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_comma_cnt <= w_comma_cnt_nxt;
      r_out       <= w_out_nxt;
    end
  end

  // Next-state logic: comma hunt, lock confirmation, sticky data mode
  always_comb begin
    w_state_nxt     = r_state;
    w_comma_cnt_nxt = r_comma_cnt;
    w_bit_cnt_nxt   = r_bit_cnt + 3'd1;
    case (r_state)
      ST_SEARCH: begin
        // Counter is parked while hunting; a match defines the boundary
        w_bit_cnt_nxt = 3'd0;
        if (w_nb_is_comma) begin
          w_comma_cnt_nxt = 4'd1;
          if (C_COMMA_TARGET == 4'd1) begin
            w_state_nxt = ST_ACTIVE;
          end else begin
            w_state_nxt = ST_ALIGN;
          end
        end
      end
      ST_ALIGN: begin
        // Only byte boundaries are inspected while confirming alignment
        if (w_boundary) begin
          if (w_nb_is_comma) begin
            w_comma_cnt_nxt = w_comma_cnt_inc;
            if (w_comma_cnt_inc == C_COMMA_TARGET) begin
              w_state_nxt = ST_ACTIVE;
            end
          end else begin
            w_state_nxt     = ST_SEARCH;
            w_comma_cnt_nxt = 4'd0;
            w_bit_cnt_nxt   = 3'd0;
          end
        end
      end
      ST_ACTIVE: begin
        // Data mode is left only through reset
        w_state_nxt = ST_ACTIVE;
      end
      default: begin
        w_state_nxt     = ST_SEARCH;
        w_comma_cnt_nxt = 4'd0;
        w_bit_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Output logic: capture each aligned byte in data mode, pulse the strobe
  always_comb begin
    w_out_nxt        = r_out;
    w_out_nxt.strobe = 1'b0;
    // active rises on the very edge that completes the last lock comma
    w_out_nxt.active = (w_state_nxt == ST_ACTIVE);
    if ((r_state == ST_ACTIVE) && w_boundary) begin
      w_out_nxt.data   = w_nb;
      w_out_nxt.valid  = ~w_nb_is_comma;
      w_out_nxt.strobe = 1'b1;
    end
  end

  assign active      = r_out.active;
  assign valid_out   = r_out.valid;
  assign data_out    = r_out.data;
  assign byte_strobe = r_out.strobe;

endmodule : serial_paralelo_rx
`default_nettype wire

// File: tb/tb_serial_paralelo_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_serial_paralelo_rx
//  Description : Self-checking bench for serial_paralelo_rx. A bit-level
//                behavioural model predicts every output on every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_paralelo_rx;

  localparam logic [7:0] BC = 8'hBC;
  localparam int         CC = 4;

  logic       clk_32f = 1'b0;
  logic       reset_L = 1'b0;
  logic       data_in = 1'b0;
  logic       active;
  logic       valid_out;
  logic [7:0] data_out;
  logic       byte_strobe;

  serial_paralelo_rx #(.COMMA(8'hBC), .COMMA_COUNT(CC)) dut (
    .clk_32f     (clk_32f),
    .reset_L     (reset_L),
    .data_in     (data_in),
    .active      (active),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .byte_strobe (byte_strobe)
  );

  always #5 clk_32f = ~clk_32f;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model: bit history, edge counter, edge where alignment was found
  logic [7:0] m_hist;
  int         m_t, m_base, m_commas;
  bit         m_aligning, m_act;
  logic [7:0] m_data;
  bit         m_valid, m_strobe;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist = 8'h00; m_t = 0; m_base = 0; m_commas = 0;
    m_aligning = 0; m_act = 0; m_data = 8'h00; m_valid = 0; m_strobe = 0;
  endtask

  // One received bit: a byte is the last 8 bits; aligned bytes complete
  // every 8 edges after the edge where the first comma was seen.
  task automatic model_step(input logic b);
    logic [7:0] nb;
    nb = {m_hist[6:0], b};
    m_hist = nb;
    m_t++;
    m_strobe = 0;
    if (!m_aligning && !m_act) begin
      if (nb == BC) begin
        m_base = m_t;
        m_commas = 1;
        if (m_commas >= CC) m_act = 1;
        else m_aligning = 1;
      end
    end else if (((m_t - m_base) % 8) == 0) begin
      if (m_act) begin
        m_data = nb;
        m_valid = (nb != BC);
        m_strobe = 1;
      end else if (nb == BC) begin
        m_commas++;
        if (m_commas == CC) begin
          m_aligning = 0;
          m_act = 1;
        end
      end else begin
        m_aligning = 0;
        m_commas = 0;
      end
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk_32f) begin
    if (chk_en) begin
      check("cyc_active", active, m_act);
      check("cyc_valid", valid_out, m_valid);
      check("cyc_data", data_out, m_data);
      check("cyc_strobe", byte_strobe, m_strobe);
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    model_step(b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_commas(input int n);
    for (int i = 0; i < n; i++) send_byte(BC);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    @(negedge clk_32f);
    reset_L = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_32f);
    reset_L = 1'b1;
    chk_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    check("reset_active", active, 1'b0);
    check("reset_valid", valid_out, 1'b0);
    check("reset_data", data_out, 8'h00);
    check("reset_strobe", byte_strobe, 1'b0);
    do_reset();

    // Four commas then two data bytes
    send_commas(3);
    #1 check("lit_active_before_4th", active, 1'b0);
    send_byte(BC);
    #1 check("lit_active_edge32", active, 1'b1);
    check("lit_model_active_edge32", m_act, 1'b1);
    send_byte(8'h55);
    #1 check("lit_data_55", data_out, 8'h55);
    check("lit_valid_55", valid_out, 1'b1);
    check("lit_strobe_55", byte_strobe, 1'b1);
    check("lit_model_data_55", m_data, 8'h55);
    send_byte(8'hA3);
    #1 check("lit_data_A3", data_out, 8'hA3);
    check("lit_strobe_A3", byte_strobe, 1'b1);

    // In data mode: data, comma, data
    send_byte(8'h11);
    #1 check("lit_data_11", data_out, 8'h11);
    check("lit_valid_11", valid_out, 1'b1);
    send_byte(BC);
    #1 check("lit_data_BC", data_out, 8'hBC);
    check("lit_valid_BC", valid_out, 1'b0);
    check("lit_active_BC", active, 1'b1);
    send_byte(8'h22);
    #1 check("lit_data_22", data_out, 8'h22);
    check("lit_valid_22", valid_out, 1'b1);

    // Asynchronous reset mid-byte while active
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk_en = 1'b0;
    #3 reset_L = 1'b0;
    #1 check("arst_active", active, 1'b0);
    check("arst_valid", valid_out, 1'b0);
    check("arst_data", data_out, 8'h00);
    check("arst_strobe", byte_strobe, 1'b0);
    model_reset();
    @(negedge clk_32f);
    reset_L = 1'b1;
    chk_en = 1'b1;
    send_commas(3);
    send_byte(8'h55);
    #1 check("lit_relock_needs_4", active, 1'b0);
    send_commas(4);
    #1 check("lit_relock_active", active, 1'b1);

    // Arbitrary bit offset before the commas
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_commas(4);
    send_byte(8'h7E);
    #1 check("lit_offset_active", active, 1'b1);
    check("lit_offset_data_7E", data_out, 8'h7E);
    check("lit_offset_valid_7E", valid_out, 1'b1);

    // Broken comma run falls back to search
    do_reset();
    send_commas(3);
    send_byte(8'h12);
    #1 check("lit_broken_active", active, 1'b0);
    send_commas(4);
    send_byte(8'h34);
    #1 check("lit_broken_active_after", active, 1'b1);
    check("lit_broken_data_34", data_out, 8'h34);
    check("lit_broken_valid_34", valid_out, 1'b1);

    // Randomized streams: junk offset, variable comma runs, mixed traffic
    for (int r = 0; r < 8; r++) begin
      do_reset();
      repeat ($urandom_range(0, 7)) send_bit(1'($urandom_range(0, 1)));
      send_commas($urandom_range(2, 5));
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(0, 9) < 3) send_byte(BC);
        else send_byte(8'($urandom_range(0, 255)));
      end
    end

    @(negedge clk_32f);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_serial_paralelo_rx
`default_nettype wire

// File: doc/serial_paralelo_rx.md
Name: serial_paralelo_rx

Overview:
Receive-side serial-to-parallel converter of the Phy. Takes the 1-bit serial line, finds byte alignment from the comma character 0xBC, and declares the link active after COMMA_COUNT consecutive aligned commas. It then delivers each non-comma byte with a valid flag. Its data_out and valid_out drive data_in0_demuxL2 and valid of the RX 1-to-2 demux directly downstream.

Parameters:
- COMMA, 8'hBC, idle/alignment character; never delivered as valid data.
- COMMA_COUNT, 4, consecutive aligned commas needed before active asserts (legal range 1..15).

Ports:
- clk_32f, input, 1, bit clock; the only clock.
- reset_L, input, 1, asynchronous active-low reset.
- data_in, input, 1, serial bit, MSB of each byte first, sampled on rising clk_32f.
- active, output, 1, link aligned and in data mode.
- valid_out, output, 1, data_out holds a non-comma byte.
- data_out, output, 8, last deserialized byte.
- byte_strobe, output, 1, one-cycle pulse on the edge where data_out/valid_out update (ACTIVE only).

Behaviour:
- Reset (async, reset_L=0): state=SEARCH, shift reg=0, bit_cnt=0, comma_cnt=0, active=0, valid_out=0, data_out=8'h00, byte_strobe=0.
- Shift register sr[7:0] shifts every edge: sr <= {sr[6:0], data_in}. Candidate byte nb = {sr[6:0], data_in}.
- SEARCH:
  - nb is compared to COMMA on every edge.
  - On a match: go to ALIGN, comma_cnt=1, bit_cnt=0. That edge defines the byte boundary.
  - If COMMA_COUNT==1, go directly to ACTIVE instead.
- bit_cnt (3 bits) increments each edge outside SEARCH and wraps 7->0. A boundary edge is one where bit_cnt==7.
- ALIGN, on a boundary edge:
  - nb==COMMA: comma_cnt+1. When it reaches COMMA_COUNT, go to ACTIVE and set active=1 on that edge.
  - nb!=COMMA: go to SEARCH, comma_cnt=0.
  - No other bit positions are checked in ALIGN.
- ACTIVE, on each boundary edge:
  - data_out <= nb.
  - valid_out <= (nb != COMMA).
  - byte_strobe=1 for that single cycle.
  - Between boundary edges, data_out and valid_out hold, i.e. they are stable for 8 clk_32f cycles = one clk_4f period.
- ACTIVE is sticky: commas or any data keep it; only reset leaves it.
- Latency: the last bit of a byte sampled at edge N appears on data_out/valid_out after edge N (0 extra cycles).
- Reset mid-operation: all state clears immediately. Alignment must be reacquired from SEARCH after release.
- Outputs are all registered; no combinational path from data_in to any output.

Decomposition:
- Shared Phy package/include holds:
  - COMMA constant 8'hBC.
  - State encodings SEARCH=2'd0, ALIGN=2'd1, ACTIVE=2'd2.
  - Byte width constant 8.
  The same constants are shared with the TX parallel-to-serial block.
- No sub-module needed. A comma comparator is inline; the single FSM + counters fit in one module of roughly 150 lines.

Test Plan:
- Reset asserted at random mid-byte with active=1 -> active, valid_out, data_out, byte_strobe all 0 asynchronously. After release, 4 commas are needed again before active=1.
- Serial 0xBC x4 then 0x55, 0xA3 -> active=1 on the 32nd bit edge. data_out=0x55 with valid_out=1 after bit 40, then 0xA3 after bit 48. byte_strobe pulses each time.
- 3 bits of junk (101) then 0xBC x4, 0x7E -> alignment found on the 8th bit of the first comma. active=1 and 0x7E valid, proving arbitrary bit offset is handled.
- 0xBC x3 then 0x12, then 0xBC x4, 0x34 -> return to SEARCH after 0x12 with active staying 0. After the next 4 commas, active=1 and 0x34 valid; 0x12 is never output.
- In ACTIVE: 0x11, 0xBC, 0x22 -> valid_out goes 1, 0, 1. data_out goes 0x11, 0xBC, 0x22. active stays 1 throughout. Each value holds exactly 8 cycles.
